// File: rtl/hash_engine_arbiter.sv
// Round-robin arbiter that lends one shared SHA-256 engine to NUM_REQ requesters, one whole
// message per grant. Define ARB_TIMEOUT_EN to abort a message that stalls for TIMEOUT cycles.
module hash_engine_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [255:0]              digest,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      hash_start,
  output logic [DATA_W-1:0]         hash_data,
  output logic                      hash_valid,
  output logic                      hash_last,
  input  logic                      hash_ready,
  input  logic                      hash_complete,
  input  logic [255:0]              hash_result
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StStream, StWaitHash, StDone} state_e;

  state_e              r_state, w_state_next;
  logic [NUM_REQ-1:0]  r_grant, w_grant_next;
  logic [IdxW-1:0]     r_last_grant, w_last_grant_next;
  logic [31:0]         r_beat_cnt, w_beat_cnt_next;
  logic [255:0]        r_digest, w_digest_next;

  logic                w_pick_found;
  logic [IdxW-1:0]     w_pick_idx;
  logic [DATA_W-1:0]   w_word;
  logic                w_stream;
  logic                w_valid;
  logic                w_last;
  logic                w_beat;
  logic                w_timeout;

  // Scan starts one past the previous owner so every requester gets a turn.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      if (!w_pick_found && req_valid[(int'(r_last_grant) + k) % int'(NUM_REQ)]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = IdxW'((int'(r_last_grant) + k) % int'(NUM_REQ));
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (r_last_grant == IdxW'(i)) w_word = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_stream = (r_state == StStream);
  assign w_valid  = w_stream && |(req_valid & r_grant);
  assign w_last   = w_valid && |(req_last & r_grant);
  assign w_beat   = w_valid && hash_ready;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TIMEOUT + 1);

  logic [StallW-1:0] r_stall, w_stall_next;

  // Counts consecutive cycles without progress; any other state leaves it cleared.
  always_comb begin
    w_stall_next = '0;
    w_timeout    = 1'b0;
    if ((w_stream && !w_beat) || (r_state == StWaitHash && !hash_complete)) begin
      if (r_stall == StallW'(TIMEOUT - 1)) w_timeout = 1'b1;
      else                                 w_stall_next = r_stall + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stall <= '0;
    else       r_stall <= w_stall_next;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT;
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_last_grant_next = r_last_grant;
    w_beat_cnt_next   = r_beat_cnt;
    w_digest_next     = r_digest;
    unique case (r_state)
      StIdle: begin
        if (w_pick_found) begin
          w_state_next      = StStart;
          w_grant_next      = NUM_REQ'(1) << w_pick_idx;
          w_last_grant_next = w_pick_idx;
        end
      end
      StStart: begin
        w_beat_cnt_next = '0;
        w_state_next    = StStream;
      end
      StStream: begin
        if (w_beat) begin
          if (r_beat_cnt != '1) w_beat_cnt_next = r_beat_cnt + 32'd1;
          if (w_last)           w_state_next    = StWaitHash;
        end else if (w_timeout) begin
          w_state_next = StIdle;
          w_grant_next = '0;
        end
      end
      StWaitHash: begin
        if (hash_complete) begin
          w_digest_next = hash_result;
          w_state_next  = StDone;
        end else if (w_timeout) begin
          w_state_next = StIdle;
          w_grant_next = '0;
        end
      end
      StDone: begin
        w_state_next = StIdle;
        w_grant_next = '0;
      end
      default: begin
        w_state_next = StIdle;
        w_grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_grant      <= '0;
      r_last_grant <= IdxW'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_digest     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_last_grant <= w_last_grant_next;
      r_beat_cnt   <= w_beat_cnt_next;
      r_digest     <= w_digest_next;
    end
  end

  assign grant      = r_grant;
  assign busy       = (r_state != StIdle);
  assign digest     = r_digest;
  assign req_ready  = r_grant & {NUM_REQ{w_stream && hash_ready}};
  assign req_done   = (r_state == StDone) ? r_grant : '0;
  assign req_err    = w_timeout ? r_grant : '0;
  // The abort pulse doubles as an engine re-initialise to drop the partial message.
  assign hash_start = (r_state == StStart) || w_timeout;
  assign hash_data  = w_stream ? w_word : '0;
  assign hash_valid = w_valid;
  assign hash_last  = w_last;

endmodule

// File: tb/tb_hash_engine_arbiter.sv
// Self-checking bench for hash_engine_arbiter: random messages from a requester model, a stub
// engine, and a round-robin reference that predicts grant order, beats and digests.
module tb_hash_engine_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_valid, req_last, req_ready, req_done, req_err, grant;
  logic [255:0]      digest, hash_result;
  logic              busy, hash_start, hash_valid, hash_last, hash_ready, hash_complete;
  logic [DW-1:0]     hash_data;

  hash_engine_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .digest(digest), .grant(grant), .busy(busy), .hash_start(hash_start),
    .hash_data(hash_data), .hash_valid(hash_valid), .hash_last(hash_last),
    .hash_ready(hash_ready), .hash_complete(hash_complete), .hash_result(hash_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Event log, sampled mid-cycle.
  logic [DW-1:0]  beat_q[$];
  logic [NR-1:0]  beat_gnt_q[$];
  int             beat_cyc_q[$];
  int             start_cyc_q[$];
  logic [NR-1:0]  start_gnt_q[$];
  logic [NR-1:0]  done_q[$];
  int             done_cyc_q[$];
  logic [255:0]   done_dig_q[$];
  logic [NR-1:0]  err_q[$];
  int             bad_rdy = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (hash_valid && hash_ready) begin
        beat_q.push_back(hash_data);
        beat_gnt_q.push_back(grant);
        beat_cyc_q.push_back(cyc);
      end
      if (hash_start) begin
        start_cyc_q.push_back(cyc);
        start_gnt_q.push_back(grant);
      end
      if (req_done != '0) begin
        done_q.push_back(req_done);
        done_cyc_q.push_back(cyc);
        done_dig_q.push_back(digest);
      end
      if (req_err != '0) err_q.push_back(req_err);
      if ((req_ready & ~grant) != '0) bad_rdy <= bad_rdy + 1;
    end
  end

  // Reference model state.
  int            m_last;
  logic [255:0]  m_digest;
  logic [255:0]  exp_dig_q[$];
  logic [DW-1:0] msg_w[NR][$];

  function automatic int rr_pick(input int last, input logic [NR-1:0] pend);
    for (int k = 1; k <= NR; k++) if (pend[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    hash_ready = 1'b0; hash_complete = 1'b0; hash_result = '0;
    idle(2);
    reset = 1'b0;
    m_last = NR - 1;
    m_digest = '0;
  endtask

  task automatic new_msg(input int r, input int n);
    msg_w[r].delete();
    for (int i = 0; i < n; i++) msg_w[r].push_back($urandom);
  endtask

  // Requester r offers its words; the first presentation is always valid.
  task automatic drive_msg(input int r, input int n, input int vprob);
    int i = 0;
    int guard = 0;
    bit fire;
    while (i < n && guard < 1000) begin
      req_data[r*DW +: DW] = msg_w[r][i];
      req_last[r] = (i == n - 1);
      req_valid[r] = (guard == 0) || (int'($urandom_range(99)) < vprob);
      @(negedge clk);
      fire = req_valid[r] && req_ready[r];
      @(posedge clk);
      #1;
      if (fire) i++;
      guard++;
    end
    n_vec++;
    if (i != n) begin
      n_err++;
      $display("FAIL drive_msg r=%0d: words accepted %0d, required %0d", r, i, n);
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  // Stub engine: ready pattern by mode (0 always, 1 alternate, 2 random); digest lat cycles
  // after the last word.
  task automatic engine(input int nmsg, input int lat, input int mode);
    int done_n = 0;
    int wait_c = -1;
    int t = 0;
    while (done_n < nmsg && t < 2000) begin
      hash_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 0) : 1'($urandom_range(1));
      hash_complete = 1'b0;
      if (wait_c == 0) begin
        hash_complete = 1'b1;
        hash_result = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
        exp_dig_q.push_back(hash_result);
        m_digest = hash_result;
        done_n++;
        wait_c = -1;
      end else if (wait_c > 0) begin
        wait_c--;
      end
      @(negedge clk);
      if (wait_c < 0 && hash_valid && hash_ready && hash_last) wait_c = lat - 1;
      @(posedge clk);
      #1;
      t++;
    end
    hash_complete = 1'b0;
    hash_ready = 1'b0;
    n_vec++;
    if (done_n != nmsg) begin
      n_err++;
      $display("FAIL engine: digests returned %0d, required %0d", done_n, nmsg);
    end
  endtask

  task automatic hold_noise(output int hits);
    int g = 0;
    bit seen_last = 1'b0;
    hits = 0;
    req_data[DW +: DW] = $urandom;
    req_last[1] = 1'b0;
    req_valid[1] = 1'b1;
    while (!seen_last && g < 200) begin
      @(negedge clk);
      if (req_ready[1]) hits++;
      if (hash_valid && hash_ready && hash_last) seen_last = 1'b1;
      @(posedge clk);
      #1;
      g++;
    end
    req_valid[1] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_vec += 4;
    if (grant !== '0) begin n_err++; $display("FAIL reset_grant: got %b want 0", grant); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (req_ready !== '0 || hash_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: req_ready %b hash_valid %b want 0", req_ready, hash_valid);
    end
    if (req_done !== '0 || req_err !== '0 || hash_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pulses: done %b err %b start %b want 0", req_done, req_err, hash_start);
    end
    apply_reset();
    @(negedge clk);
    n_vec++;
    if (digest !== '0) begin n_err++; $display("FAIL reset_digest: got %h want 0", digest); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int bb = beat_q.size();
    int sb = start_cyc_q.size();
    int db = done_q.size();
    int eb = exp_dig_q.size();
    int t0;
    new_msg(0, 4);
    t0 = cyc;
    fork
      drive_msg(0, 4, 100);
      engine(1, 3, 0);
    join
    idle(4);
    m_last = 0;
    n_vec += 4;
    if (start_cyc_q.size() != sb + 1 || start_cyc_q[sb] != t0 + 1) begin
      n_err++; $display("FAIL single_start: starts %0d at %0d want 1 at %0d",
                        start_cyc_q.size() - sb, start_cyc_q[sb], t0 + 1);
    end
    if (beat_q.size() != bb + 4) begin
      n_err++; $display("FAIL single_beats: got %0d want 4", beat_q.size() - bb);
    end else if (beat_cyc_q[bb] != t0 + 2 || beat_cyc_q[bb+3] != t0 + 5) begin
      n_err++; $display("FAIL single_beat_time: first %0d last %0d want %0d %0d",
                        beat_cyc_q[bb], beat_cyc_q[bb+3], t0 + 2, t0 + 5);
    end
    if (done_q.size() != db + 1 || done_q[db] !== 2'b01 || done_cyc_q[db] != t0 + 9) begin
      n_err++; $display("FAIL single_done: n %0d vec %b at %0d want 01 at %0d",
                        done_q.size() - db, done_q[db], done_cyc_q[db], t0 + 9);
    end
    if (done_dig_q[db] !== exp_dig_q[eb]) begin
      n_err++; $display("FAIL single_digest: got %h want %h", done_dig_q[db], exp_dig_q[eb]);
    end
    for (int i = 0; i < 4 && bb + i < beat_q.size(); i++) begin
      n_vec++;
      if (beat_q[bb+i] !== msg_w[0][i]) begin
        n_err++; $display("FAIL single_word%0d: got %h want %h", i, beat_q[bb+i], msg_w[0][i]);
      end
    end
    n_vec++;
    if (dut.r_beat_cnt !== 32'd4) begin
      n_err++; $display("FAIL single_beat_cnt: got %0d want 4", dut.r_beat_cnt);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int rnd = 0; rnd < 3; rnd++) begin
      int n[NR];
      int g0, g1, bb, sb, db, eb;
      logic [DW-1:0] exp_w[$];
      logic [NR-1:0] exp_g[$];
      bb = beat_q.size(); sb = start_gnt_q.size(); db = done_q.size(); eb = exp_dig_q.size();
      for (int r = 0; r < NR; r++) begin
        n[r] = int'($urandom_range(5, 1));
        new_msg(r, n[r]);
      end
      g0 = rr_pick(m_last, 2'b11);
      g1 = rr_pick(g0, 2'b11 & ~(NR'(1) << g0));
      m_last = g1;
      foreach (msg_w[g0][i]) begin exp_w.push_back(msg_w[g0][i]); exp_g.push_back(NR'(1) << g0); end
      foreach (msg_w[g1][i]) begin exp_w.push_back(msg_w[g1][i]); exp_g.push_back(NR'(1) << g1); end
      fork
        drive_msg(0, n[0], 70);
        drive_msg(1, n[1], 70);
        engine(2, int'($urandom_range(4, 1)), 2);
      join
      idle(3);
      n_vec += 3;
      if (start_gnt_q[sb] !== NR'(1) << g0 || start_gnt_q[sb+1] !== NR'(1) << g1) begin
        n_err++; $display("FAIL rr%0d_grant: got %b,%b want %0d,%0d",
                          rnd, start_gnt_q[sb], start_gnt_q[sb+1], g0, g1);
      end
      if (beat_q.size() - bb != exp_w.size()) begin
        n_err++; $display("FAIL rr%0d_beats: got %0d want %0d", rnd, beat_q.size() - bb, exp_w.size());
      end
      if (done_q.size() != db + 2 || done_dig_q[db] !== exp_dig_q[eb]
          || done_dig_q[db+1] !== exp_dig_q[eb+1] || done_q[db+1] !== NR'(1) << g1) begin
        n_err++; $display("FAIL rr%0d_done: n %0d last %b digest %h want %h", rnd,
                          done_q.size() - db, done_q[db+1], done_dig_q[db+1], exp_dig_q[eb+1]);
      end
      for (int i = 0; i < exp_w.size() && bb + i < beat_q.size(); i++) begin
        n_vec++;
        if (beat_q[bb+i] !== exp_w[i] || beat_gnt_q[bb+i] !== exp_g[i]) begin
          n_err++; $display("FAIL rr%0d_word%0d: got %h/%b want %h/%b", rnd, i,
                            beat_q[bb+i], beat_gnt_q[bb+i], exp_w[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_ready_toggle();
    int bb = beat_q.size();
    int db = done_q.size();
    int eb = exp_dig_q.size();
    int br = bad_rdy;
    int hits;
    new_msg(0, 3);
    m_last = rr_pick(m_last, 2'b11);
    fork
      drive_msg(0, 3, 100);
      engine(1, 2, 1);
      hold_noise(hits);
    join
    idle(3);
    n_vec += 4;
    if (m_last != 0) begin n_err++; $display("FAIL toggle_order: model owner %0d want 0", m_last); end
    if (beat_q.size() - bb != 3) begin
      n_err++; $display("FAIL toggle_beats: got %0d want 3", beat_q.size() - bb);
    end
    if (hits != 0 || bad_rdy != br) begin
      n_err++; $display("FAIL toggle_rdy1: req_ready[1] hits %0d stray %0d want 0", hits, bad_rdy - br);
    end
    if (done_q.size() != db + 1 || done_dig_q[db] !== exp_dig_q[eb]) begin
      n_err++; $display("FAIL toggle_done: n %0d digest %h want %h",
                        done_q.size() - db, done_dig_q[db], exp_dig_q[eb]);
    end
    for (int i = 0; i < 3 && bb + i < beat_q.size(); i++) begin
      n_vec++;
      if (beat_q[bb+i] !== msg_w[0][i]) begin
        n_err++; $display("FAIL toggle_word%0d: got %h want %h", i, beat_q[bb+i], msg_w[0][i]);
      end
    end
  endtask

  task automatic test_spurious();
    int db = done_q.size();
    hash_complete = 1'b1;
    hash_result = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (digest !== m_digest || busy !== 1'b0) begin
        n_err++; $display("FAIL spurious%0d: digest %h busy %b want %h 0", i, digest, busy, m_digest);
      end
      @(posedge clk);
      #1;
    end
    hash_complete = 1'b0;
    idle(1);
    n_vec++;
    if (done_q.size() != db) begin
      n_err++; $display("FAIL spurious_done: pulses %0d want 0", done_q.size() - db);
    end
  endtask

  task automatic test_reset_mid();
    req_data[0 +: DW] = $urandom;
    req_last[0] = 1'b0;
    req_valid[0] = 1'b1;
    hash_ready = 1'b1;
    idle(3);
    n_vec++;
    if (!(busy === 1'b1 && hash_valid === 1'b1)) begin
      n_err++; $display("FAIL mid_stream: busy %b hash_valid %b want 1 1", busy, hash_valid);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (grant !== '0 || busy !== 1'b0 || req_ready !== '0 || hash_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: grant %b busy %b ready %b hvalid %b want 0",
                        grant, busy, req_ready, hash_valid);
    end
    #1;
    reset = 1'b0;
    m_last = NR - 1;
    m_digest = '0;
    idle(1);
    n_vec++;
    if (hash_start !== 1'b1 || grant !== NR'(1) << rr_pick(m_last, req_valid)) begin
      n_err++; $display("FAIL mid_restart: start %b grant %b want 1 01", hash_start, grant);
    end
    apply_reset();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int t0, b = -1, e = -1, g = 0, db, sb;
    logic [NR-1:0] errv = '0;
    logic st = 1'b0;
    apply_reset();
    db = done_q.size();
    req_data[DW +: DW] = $urandom;
    req_last[1] = 1'b0;
    req_valid[1] = 1'b1;
    hash_ready = 1'b1;
    t0 = cyc;
    while (e < 0 && g < 60) begin
      @(negedge clk);
      if (req_valid[1] && req_ready[1]) b = cyc;
      if (req_err != '0) begin e = cyc; errv = req_err; st = hash_start; end
      @(posedge clk);
      #1;
      if (b >= 0) req_valid[1] = 1'b0;
      g++;
    end
    m_last = 1;
    n_vec += 4;
    if (b != t0 + 2) begin n_err++; $display("FAIL to_beat: at %0d want %0d", b, t0 + 2); end
    if (e != b + TO || errv !== 2'b10 || st !== 1'b1) begin
      n_err++; $display("FAIL to_err: at %0d vec %b start %b want %0d 10 1", e, errv, st, b + TO);
    end
    if (busy !== 1'b0 || grant !== '0) begin
      n_err++; $display("FAIL to_idle: busy %b grant %b want 0", busy, grant);
    end
    if (digest !== m_digest || done_q.size() != db) begin
      n_err++; $display("FAIL to_nodone: digest %h done %0d want %h 0", digest, done_q.size() - db, m_digest);
    end
    new_msg(0, 1);
    new_msg(1, 1);
    sb = start_gnt_q.size();
    fork
      drive_msg(0, 1, 100);
      drive_msg(1, 1, 100);
      engine(2, 2, 0);
    join
    idle(3);
    n_vec++;
    if (start_gnt_q[sb] !== NR'(1) << rr_pick(m_last, 2'b11)) begin
      n_err++; $display("FAIL to_next_grant: got %b want 01", start_gnt_q[sb]);
    end
  endtask
`else
  task automatic test_no_err();
    n_vec++;
    if (err_q.size() != 0 || req_err !== '0) begin
      n_err++; $display("FAIL no_err: pulses %0d req_err %b want 0", err_q.size(), req_err);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    hash_ready = 1'b0; hash_complete = 1'b0; hash_result = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_ready_toggle();
    test_spurious();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
